// File: rtl/noc_pkg.sv
// Shared NoC packet definitions, also used by the switch and generator code.
package noc_pkg;

  localparam int NODE_ADDR_W = 3;
  localparam int DEST_LSB    = 24;
  localparam int TYPE_LSB    = 16;
  localparam int PKT_W       = 32;

  typedef struct packed {
    logic [4:0]             rsvd;
    logic [NODE_ADDR_W-1:0] dest;
    logic [7:0]             ptype;
    logic [15:0]            payload;
  } noc_pkt_t;

  function automatic logic addr_match(input logic [NODE_ADDR_W-1:0] dest,
                                      input logic [NODE_ADDR_W-1:0] addr,
                                      input logic [NODE_ADDR_W-1:0] mask);
    return ((dest & mask) == (addr & mask));
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is allowed
// only alongside a pop. While empty, data_o holds the last popped word.
module noc_sync_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        hold_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/noc_pe_receiver.sv
// Ejection endpoint: two-phase bundled-data receiver feeding a valid/ready
// stream to the local PE. NOC_RX_STATS_EN adds rx_count/drop_count outputs.
module noc_pe_receiver
  import noc_pkg::*;
#(
  parameter int                     WIDTH       = 32,
  parameter logic [NODE_ADDR_W-1:0] ADDRESS     = 3'b000,
  parameter logic [NODE_ADDR_W-1:0] MASK        = 3'b111,
  parameter int                     DEPTH       = 4,
  parameter int                     SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_req,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NODE_ADDR_W-1:0] out_dest,
  output logic [7:0]             out_type,
  output logic [15:0]            out_payload,
  output logic                   err_misroute,
`ifdef NOC_RX_STATS_EN
  output logic [15:0]            rx_count,
  output logic [15:0]            drop_count,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int FW = NODE_ADDR_W + 8 + 16;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   ack_q;
  logic                   ack_d;
  logic                   err_q;
  logic                   err_d;
  logic                   req_s;
  logic                   pending;
  logic                   accept;
  logic                   match;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FW-1:0]          head;
  noc_pkt_t               pkt;
  logic                   unused_rsvd;

  assign pkt         = noc_pkt_t'(in_data[PKT_W-1:0]);
  assign unused_rsvd = ^pkt.rsvd;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], in_req};
  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = req_s ^ ack_q;
  assign match   = addr_match(pkt.dest, ADDRESS, MASK);

  // Stream handshake: the head moves to the PE on any rising edge where
  // out_valid and out_ready are both high; out_valid never waits on out_ready,
  // and the head fields stay stable while out_valid is high and not yet taken.
  assign pop    = out_valid & out_ready;
  // A full FIFO still takes a token in the same cycle a pop frees a slot.
  assign accept = pending & (~fifo_full | pop);
  assign ack_d  = ack_q ^ accept;
  assign err_d  = accept & ~match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  noc_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept & match),
    .data_i  ({pkt.dest, pkt.ptype, pkt.payload}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ack       = ack_q;
  assign err_misroute = err_q;
  assign out_valid    = ~fifo_empty;
  assign out_dest     = head[FW-1 -: NODE_ADDR_W];
  assign out_type     = head[15+8 -: 8];
  assign out_payload  = head[15:0];

`ifdef NOC_RX_STATS_EN
  logic [15:0] rx_q;
  logic [15:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q   <= '0;
      drop_q <= '0;
    end else begin
      if (accept && rx_q != 16'hFFFF) begin
        rx_q <= rx_q + 16'd1;
      end
      if (err_d && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign rx_count   = rx_q;
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_noc_pe_receiver.sv
// Directed bench for noc_pe_receiver with a two-phase sender model and a
// scoreboard of expected head words checked on every pop.
module tb_noc_pe_receiver;

  localparam logic [2:0] ADDR  = 3'b010;
  localparam logic [2:0] MSK   = 3'b110;
  localparam int         DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_req;
  logic [31:0] in_data;
  logic        in_ack;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_dest;
  logic [7:0]  out_type;
  logic [15:0] out_payload;
  logic        err_misroute;
  logic [2:0]  fifo_count;
`ifdef NOC_RX_STATS_EN
  logic [15:0] rx_count;
  logic [15:0] drop_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  noc_pe_receiver #(
    .WIDTH       (32),
    .ADDRESS     (ADDR),
    .MASK        (MSK),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_req       (in_req),
    .in_data      (in_data),
    .in_ack       (in_ack),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dest     (out_dest),
    .out_type     (out_type),
    .out_payload  (out_payload),
    .err_misroute (err_misroute),
`ifdef NOC_RX_STATS_EN
    .rx_count     (rx_count),
    .drop_count   (drop_count),
`endif
    .fifo_count   (fifo_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tb_match(input logic [31:0] w);
    return ((w[26:24] & MSK) == (ADDR & MSK));
  endfunction

  // Driver: present a word, toggle req, wait (bounded) for the matching ack.
  task automatic send_token(input logic [31:0] w, input logic rand_ready);
    logic got;
    in_data = w;
    if (tb_match(w)) exp_q.push_back(w);
    in_req = ~in_req;
    got = 1'b0;
    for (int c = 0; c < 24 && !got; c++) begin
      tick();
      if (in_ack == in_req) got = 1'b1;
      else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    check("send_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic drain();
    logic done;
    out_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (!out_valid) done = 1'b1;
    end
    out_ready = 1'b0;
    check("drain_done", {31'd0, done}, 32'd1);
    check("drain_sb_empty", exp_q.size(), 32'd0);
    check("drain_count", {29'd0, fifo_count}, 32'd0);
  endtask

  // Scoreboard: compare the head against the oldest expected word on each pop.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("pop_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pop_fields", {5'd0, out_dest, out_type, out_payload}, {5'd0, e[26:0]});
      end
    end
  end

  initial begin
    logic ack_old;
    rst       = 1'b1;
    in_req    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    check("rst_ack", {31'd0, in_ack}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_err", {31'd0, err_misroute}, 32'd0);
    check("rst_fields", {5'd0, out_dest, out_type, out_payload}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single token: ack toggles exactly at edge k+2
    in_data = 32'h0200_000C;
    exp_q.push_back(in_data);
    in_req = ~in_req;
    tick();
    check("t1_ack_k", {31'd0, in_ack}, 32'd0);
    tick();
    check("t1_ack_k1", {31'd0, in_ack}, 32'd0);
    tick();
    check("t1_ack_k2", {31'd0, in_ack}, 32'd1);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_count", {29'd0, fifo_count}, 32'd1);
    check("t1_dest", {29'd0, out_dest}, 32'd2);
    check("t1_type", {24'd0, out_type}, 32'd0);
    check("t1_payload", {16'd0, out_payload}, 32'h000C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_popped", {31'd0, out_valid}, 32'd0);

    // Misroute: acked, flagged for one cycle, not stored
    in_data = 32'h0100_0009;
    in_req = ~in_req;
    tick();
    tick();
    tick();
    check("mr_ack", {31'd0, in_ack}, 32'd0);
    check("mr_err", {31'd0, err_misroute}, 32'd1);
    check("mr_count", {29'd0, fifo_count}, 32'd0);
    check("mr_valid", {31'd0, out_valid}, 32'd0);
`ifdef NOC_RX_STATS_EN
    check("mr_drop_count", {16'd0, drop_count}, 32'd1);
`endif
    tick();
    check("mr_err_pulse", {31'd0, err_misroute}, 32'd0);
    send_token(32'h0100_0007, 1'b0);
    check("mr2_count", {29'd0, fifo_count}, 32'd0);

    // Backpressure and full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_token(32'h0200_0010 + 32'(i), 1'b0);
    check("bp_count_full", {29'd0, fifo_count}, 32'd4);
    in_data = 32'h0200_0014;
    exp_q.push_back(in_data);
    ack_old = in_ack;
    in_req = ~in_req;
    repeat (6) tick();
    check("bp_ack_held", {31'd0, in_ack}, {31'd0, ack_old});
    check("bp_count_held", {29'd0, fifo_count}, 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ack_after_pop", {31'd0, in_ack}, {31'd0, ~ack_old});
    check("bp_count_same", {29'd0, fifo_count}, 32'd4);
    drain();

    // Ordering with random backpressure
    for (int i = 1; i <= 8; i++) send_token(32'h0200_0000 + 32'(i), 1'b1);
    drain();

    // Wrap-around across 3*DEPTH tokens
    for (int i = 0; i < 3 * DEPTH; i++) begin
      send_token({5'h1F, 3'b011, 8'(i), 16'hA000 + 16'(i)}, 1'b1);
      check("wrap_count_le4", {31'd0, fifo_count <= 3'd4}, 32'd1);
    end
    drain();

    // Reset mid-operation with entries queued and a token pending
    for (int i = 0; i < 3; i++) send_token(32'h0200_0050 + 32'(i), 1'b0);
    check("mid_count3", {29'd0, fifo_count}, 32'd3);
    check("mid_ack_before", {31'd0, in_ack}, 32'd1);
    in_data = 32'h0200_0060;
    in_req = ~in_req;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ack", {31'd0, in_ack}, 32'd0);
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    exp_q.delete();
    in_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    send_token(32'h0200_00AA, 1'b0);
    check("post_rst_count", {29'd0, fifo_count}, 32'd1);
    check("post_rst_payload", {16'd0, out_payload}, 32'h00AA);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
